// File: rtl/rx_byte_fifo.sv
// rx_byte_fifo: receive byte buffer behind the UART RX controller.
// Each rising edge of the done strobe captures one byte. The head byte is
// presented first-word-fall-through on a valid/ready port. A sticky overrun
// flag records any byte dropped while the FIFO was full.
module rx_byte_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_rx_done,
  input  logic [7:0]        i_rx_data,
  output logic [7:0]        o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [ADDR_W:0]   o_count,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_overrun,
  input  logic              i_clr_ovr
);

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              done_q, done_d;
  logic              overrun_q, overrun_d;

  logic empty, full, wr, rd, wr_accept, drop;

  // Event decode and next-state computation for pointers, count and overrun.
  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == (ADDR_W+1)'(DEPTH));
    wr        = i_rx_done & ~done_q;
    rd        = ~empty & i_ready;
    // When full, a same-cycle pop frees the slot the write lands in.
    wr_accept = wr & (~full | rd);
    drop      = wr & full & ~rd;

    done_d    = i_rx_done;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;

    if (wr_accept) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (rd)        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    count_d = count_q + (ADDR_W+1)'(wr_accept) - (ADDR_W+1)'(rd);

    // A new drop outranks a clear in the same cycle.
    if (drop)           overrun_d = 1'b1;
    else if (i_clr_ovr) overrun_d = 1'b0;
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage write port; contents are not reset, reset only discards them.
  always_ff @(posedge clk) begin
    if (!reset && wr_accept) mem_q[wr_ptr_q] <= i_rx_data;
  end

  // Combinational head-of-FIFO presentation and status outputs.
  always_comb begin
    o_data    = empty ? 8'h00 : mem_q[rd_ptr_q];
    o_valid   = ~empty;
    o_empty   = empty;
    o_full    = full;
    o_count   = count_q;
    o_overrun = overrun_q;
  end

endmodule
